mem_responder: RTL and testbench

- Memory-side responder for the SLC-3 active-low SRAM strobe interface (Mem_CE/UB/LB/OE/WE) driven by the control unit.
- Holds a byte-enabled 16-bit word array.
- Answers read strobes with registered data after a configurable latency, and commits write strobes exactly once per strobe run.
- Replaces the external SRAM for simulation and on-chip builds. Sits between the MAR/MDR datapath and the memory bus.

---
 rtl/mem_resp_pkg.sv | 15 +
 rtl/mem_responder_if.sv | 27 ++
 rtl/mem_resp_array.sv | 37 +++
 rtl/mem_responder.sv | 126 ++++++++++++
 tb/tb_mem_responder.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared widths and FSM state type for the SRAM-strobe memory responder
package mem_resp_pkg;

    localparam int DATA_W = 16;
    localparam int MAR_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_HOLD,
        WR_WAIT,
        WR_DONE
    } mem_resp_state_t;

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - active-low SRAM strobe bus between control unit (master) and memory (slave)
interface mem_responder_if;
    import mem_resp_pkg::*;

    logic              Mem_CE;
    logic              Mem_UB;
    logic              Mem_LB;
    logic              Mem_OE;
    logic              Mem_WE;
    logic [MAR_W-1:0]  ADDR;
    logic [DATA_W-1:0] Data_to_mem;
    logic [DATA_W-1:0] Data_from_mem;
    logic              Data_valid;
    logic              Mem_busy;
    logic              Range_err;

    modport master (
        output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_to_mem,
        input  Data_from_mem, Data_valid, Mem_busy, Range_err
    );

    modport slave (
        input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_to_mem,
        output Data_from_mem, Data_valid, Mem_busy, Range_err
    );

endinterface

// File: rtl/mem_resp_array.sv
// rtl/mem_resp_array.sv - single-port 2**ADDR_W x 16 RAM, byte write enables, registered read port
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_en_i,
    input  logic              rd_zero_i,
    input  logic              we_hi_i,
    input  logic              we_lo_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Storage carries no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_hi_i) mem_q[addr_i][15:8] <= wdata_i[15:8];
        if (we_lo_i) mem_q[addr_i][7:0]  <= wdata_i[7:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= rd_zero_i ? '0 : mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - SRAM-strobe memory responder FSM; MEM_RESP_RANGE_CHECK_EN enables out-of-range detection
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W        = 10,
    parameter int READ_LATENCY  = 1,
    parameter int WRITE_LATENCY = 1
) (
    input  logic           Clk,
    input  logic           Reset,
    mem_responder_if.slave bus
);

    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    mem_resp_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q;
    logic             range_err_q;
    logic             rd_fire, wr_fire;
    logic             rd_ok, wr_ok;
    logic             out_of_range;

`ifdef MEM_RESP_RANGE_CHECK_EN
    assign out_of_range = |(bus.ADDR >> ADDR_W);
`else
    logic unused_addr_hi;
    assign out_of_range   = 1'b0;
    assign unused_addr_hi = |(bus.ADDR >> ADDR_W);
`endif

    // WE low always wins, so a read strobe is only valid with WE released.
    assign rd_ok = !bus.Mem_CE && !bus.Mem_OE && bus.Mem_WE;
    assign wr_ok = !bus.Mem_CE && !bus.Mem_WE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_fire = 1'b0;
        wr_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_ok) begin
                    if (WRITE_LATENCY == 1) begin
                        wr_fire = 1'b1;
                        state_d = WR_DONE;
                    end else begin
                        cnt_d   = CNT_W'(WRITE_LATENCY - 1);
                        state_d = WR_WAIT;
                    end
                end else if (rd_ok) begin
                    if (READ_LATENCY == 1) begin
                        rd_fire = 1'b1;
                        state_d = RD_HOLD;
                    end else begin
                        cnt_d   = CNT_W'(READ_LATENCY - 1);
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (!rd_ok) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    rd_fire = 1'b1;
                    cnt_d   = '0;
                    state_d = RD_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RD_HOLD: begin
                if (!rd_ok) state_d = IDLE;
            end
            WR_WAIT: begin
                if (!wr_ok) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    wr_fire = 1'b1;
                    cnt_d   = '0;
                    state_d = WR_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_DONE: begin
                if (!wr_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= (state_d != IDLE);
            range_err_q <= (rd_fire || wr_fire) && out_of_range;
        end
    end

    mem_resp_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .rd_en_i   (rd_fire && !Reset),
        .rd_zero_i (out_of_range),
        .we_hi_i   (wr_fire && !Reset && !out_of_range && !bus.Mem_UB),
        .we_lo_i   (wr_fire && !Reset && !out_of_range && !bus.Mem_LB),
        .addr_i    (bus.ADDR[ADDR_W-1:0]),
        .wdata_i   (bus.Data_to_mem),
        .rdata_o   (bus.Data_from_mem)
    );

    assign bus.Data_valid = (state_q == RD_HOLD);
    assign bus.Mem_busy   = busy_q;
    assign bus.Range_err  = range_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench: default DUT (A) and READ_LATENCY=3/WRITE_LATENCY=2 DUT (B)
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic        ce, ub, lb, oe, we;
    logic [15:0] addr, wd;

    mem_responder_if bus_a ();
    mem_responder_if bus_b ();

    assign bus_a.Mem_CE = ce;  assign bus_b.Mem_CE = ce;
    assign bus_a.Mem_UB = ub;  assign bus_b.Mem_UB = ub;
    assign bus_a.Mem_LB = lb;  assign bus_b.Mem_LB = lb;
    assign bus_a.Mem_OE = oe;  assign bus_b.Mem_OE = oe;
    assign bus_a.Mem_WE = we;  assign bus_b.Mem_WE = we;
    assign bus_a.ADDR   = addr; assign bus_b.ADDR  = addr;
    assign bus_a.Data_to_mem = wd; assign bus_b.Data_to_mem = wd;

    mem_responder #(.ADDR_W(10), .READ_LATENCY(1), .WRITE_LATENCY(1)) dut_a (
        .Clk   (clk),
        .Reset (rst_a),
        .bus   (bus_a.slave)
    );

    mem_responder #(.ADDR_W(10), .READ_LATENCY(3), .WRITE_LATENCY(2)) dut_b (
        .Clk   (clk),
        .Reset (rst_b),
        .bus   (bus_b.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] mdl   [1024];
    bit          known [1024];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_oor(input logic [15:0] a);
`ifdef MEM_RESP_RANGE_CHECK_EN
        return a[15:10] != 6'd0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void m_write(input logic [15:0] a, input logic [15:0] d, input logic u, input logic l);
        logic [9:0] idx;
        idx = a[9:0];
        if (is_oor(a)) return;
        if (!u) mdl[idx][15:8] = d[15:8];
        if (!l) mdl[idx][7:0]  = d[7:0];
        if (!u && !l) known[idx] = 1'b1;
    endfunction

    function automatic logic [15:0] m_read(input logic [15:0] a);
        return is_oor(a) ? 16'h0000 : mdl[a[9:0]];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // WE held low for n cycles; data switches to d2 after the first edge.
    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic [15:0] d2,
                            input logic u, input logic l, input int n,
                            output logic re1, output logic re2);
        addr = a; wd = d; ub = u; lb = l; oe = 1'b1; we = 1'b0; ce = 1'b0;
        step();
        re1 = bus_a.Range_err;
        wd  = d2;
        re2 = 1'b0;
        for (int i = 1; i < n; i++) begin
            step();
            if (i == 1) re2 = bus_a.Range_err;
        end
        ce = 1'b1; we = 1'b1; ub = 1'b1; lb = 1'b1;
        step();
    endtask

    // OE held low for n cycles; vs[i] is Data_valid during cycle i+1.
    task automatic do_read(input logic sel, input logic [15:0] a, input int n,
                           output logic [7:0] vs, output logic [15:0] dn,
                           output logic busy2, output logic re);
        addr = a; ub = 1'b0; lb = 1'b0; we = 1'b1; oe = 1'b0; ce = 1'b0;
        vs = '0; dn = '0; busy2 = 1'b0; re = 1'b0;
        for (int i = 0; i < n; i++) begin
            vs[i] = sel ? bus_b.Data_valid : bus_a.Data_valid;
            dn    = sel ? bus_b.Data_from_mem : bus_a.Data_from_mem;
            step();
            if (i == 0) begin
                busy2 = sel ? bus_b.Mem_busy : bus_a.Mem_busy;
                re    = bus_a.Range_err;
            end
        end
        oe = 1'b1; ce = 1'b1; ub = 1'b1; lb = 1'b1;
        step();
    endtask

    initial begin
        logic [7:0]  vs;
        logic [15:0] dn;
        logic        busy2, re, re1, re2;
        logic [15:0] a, d;
        logic [9:0]  lo;
        logic [5:0]  hi;
        logic        u, l;
        int          n;

        ce = 1'b1; ub = 1'b1; lb = 1'b1; oe = 1'b1; we = 1'b1; addr = '0; wd = '0;
        rst_a = 1'b1; rst_b = 1'b1;
        for (int i = 0; i < 1024; i++) begin mdl[i] = '0; known[i] = 1'b0; end

        step(); step();
        chk("rst_a_data",  bus_a.Data_from_mem, 16'h0000);
        chk("rst_a_valid", bus_a.Data_valid, 1'b0);
        chk("rst_a_busy",  bus_a.Mem_busy, 1'b0);
        chk("rst_a_rerr",  bus_a.Range_err, 1'b0);
        chk("rst_b_data",  bus_b.Data_from_mem, 16'h0000);
        chk("rst_b_busy",  bus_b.Mem_busy, 1'b0);
        rst_a = 1'b0; rst_b = 1'b0;
        step();

        // Full word write then read back.
        do_write(16'h0005, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 2, re1, re2);
        m_write(16'h0005, 16'hBEEF, 1'b0, 1'b0);
        do_read(1'b0, 16'h0005, 2, vs, dn, busy2, re);
        chk("rd1_valid_c1", vs[0], 1'b0);
        chk("rd1_valid_c2", vs[1], 1'b1);
        chk("rd1_busy",     busy2, 1'b1);
        chk("rd1_data",     dn, m_read(16'h0005));
        chk("idle_busy",    bus_a.Mem_busy, 1'b0);

        // Lower byte only.
        do_write(16'h0005, 16'h1234, 16'h1234, 1'b1, 1'b0, 2, re1, re2);
        m_write(16'h0005, 16'h1234, 1'b1, 1'b0);
        do_read(1'b0, 16'h0005, 2, vs, dn, busy2, re);
        chk("byte_wr_data", dn, 16'hBE34);

        // Long WE run commits once, with the first-edge data.
        do_write(16'h0006, 16'h1111, 16'h2222, 1'b0, 1'b0, 5, re1, re2);
        m_write(16'h0006, 16'h1111, 1'b0, 1'b0);
        do_read(1'b0, 16'h0006, 2, vs, dn, busy2, re);
        chk("one_commit", dn, 16'h1111);

        // READ_LATENCY=3 on DUT B.
        do_write(16'h0020, 16'hAAAA, 16'hAAAA, 1'b0, 1'b0, 3, re1, re2);
        m_write(16'h0020, 16'hAAAA, 1'b0, 1'b0);
        do_read(1'b1, 16'h0020, 2, vs, dn, busy2, re);
        chk("b_short_valid", vs[1:0], 2'b00);
        chk("b_short_busy",  busy2, 1'b1);
        chk("b_short_data",  bus_b.Data_from_mem, 16'h0000);
        do_read(1'b1, 16'h0020, 4, vs, dn, busy2, re);
        chk("b_long_valid3", vs[2], 1'b0);
        chk("b_long_valid4", vs[3], 1'b1);
        chk("b_long_data",   dn, 16'hAAAA);

        // OE and WE low together: write wins.
        addr = 16'h0010; wd = 16'h0F0F; ub = 1'b0; lb = 1'b0; ce = 1'b0; oe = 1'b0; we = 1'b0;
        step();
        chk("oewe_valid_c2", bus_a.Data_valid, 1'b0);
        chk("oewe_busy",     bus_a.Mem_busy, 1'b1);
        step();
        chk("oewe_valid_c3", bus_a.Data_valid, 1'b0);
        ce = 1'b1; oe = 1'b1; we = 1'b1; ub = 1'b1; lb = 1'b1;
        step();
        m_write(16'h0010, 16'h0F0F, 1'b0, 1'b0);
        do_read(1'b0, 16'h0010, 2, vs, dn, busy2, re);
        chk("oewe_data", dn, 16'h0F0F);

        // Reset B while it sits in WR_WAIT: no commit.
        addr = 16'h0020; wd = 16'h5555; ub = 1'b0; lb = 1'b0; ce = 1'b0; we = 1'b0;
        step();
        rst_b = 1'b1;
        step();
        rst_b = 1'b0; ce = 1'b1; we = 1'b1; ub = 1'b1; lb = 1'b1;
        step();
        m_write(16'h0020, 16'h5555, 1'b0, 1'b0);
        do_read(1'b1, 16'h0020, 4, vs, dn, busy2, re);
        chk("b_rst_wr_data", dn, 16'hAAAA);
        do_read(1'b0, 16'h0020, 2, vs, dn, busy2, re);
        chk("a_commit_data", dn, m_read(16'h0020));

        // High address bits: range error or aliasing.
        do_write(16'h0405, 16'h7777, 16'h7777, 1'b0, 1'b0, 2, re1, re2);
        chk("range_pulse", re1, is_oor(16'h0405));
        chk("range_pulse_end", re2, 1'b0);
        m_write(16'h0405, 16'h7777, 1'b0, 1'b0);
        do_read(1'b0, 16'h0005, 2, vs, dn, busy2, re);
        chk("range_target", dn, m_read(16'h0005));

        for (int k = 0; k < 40; k++) begin
            lo = 10'h040 + 10'($urandom_range(0, 15));
            hi = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            a  = {hi, lo};
            if ($urandom_range(0, 1) == 1 || !known[lo]) begin
                d = 16'($urandom);
                u = ($urandom_range(0, 3) == 0);
                l = ($urandom_range(0, 3) == 0);
                n = $urandom_range(2, 4);
                do_write(a, d, 16'($urandom), u, l, n, re1, re2);
                chk("rnd_wr_rerr", re1, is_oor(a));
                chk("rnd_wr_rerr_end", re2, 1'b0);
                m_write(a, d, u, l);
            end else begin
                do_read(1'b0, a, 2, vs, dn, busy2, re);
                chk("rnd_rd_valid", vs[1:0], 2'b10);
                chk("rnd_rd_data",  dn, m_read(a));
                chk("rnd_rd_rerr",  re, is_oor(a));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
